exception_ctrl: RTL and testbench



---
 rtl/exception_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_exception_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// ----------------------------------------------------------------------------
// exception_ctrl
//
// MEM-stage exception arbiter and flush sequencer for the MIPS pipeline.
// It sits directly upstream of the CP0 register block. It collects the
// exception flags of the MEM instruction and any pending interrupt, and picks
// the highest-priority cause. It then commits that cause to CP0 one cycle
// later, together with a pipeline flush/redirect. While the flush is
// outstanding, it kills the side effects of whatever instruction has slid
// into MEM.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   valid_i              MEM holds a real instruction (not a bubble)
//   stall_i              MEM stalled this cycle
//   pc_i                 MEM instruction address
//   is_in_delayslot_i    MEM instruction sits in a branch delay slot
//   exc_flags_i[8:0]     per-instruction exception flags
//                        [0] fetch misaligned  [1] reserved instr  [2] syscall
//                        [3] break             [4] overflow        [5] trap
//                        [6] load misaligned   [7] store misaligned [8] eret
//   mem_addr_i           load/store effective address
//   cp0_we_i/waddr_i/wdata_i   mtc0 in MEM this cycle (bypassed below)
//   cp0_status_i/cause_i/epc_i current CP0 register values
//   cp0_en_o             commit strobe to CP0
//   excepttype_o         exception code to CP0
//   current_inst_addr_o  faulting PC
//   is_in_delayslot_o    delay-slot flag to CP0
//   bad_addr_o           BadVAddr source
//   flush_o, new_pc_o    flush IF..MEM and redirect target
//   kill_mem_o           suppress store / mtc0 / regfile write in MEM
// ----------------------------------------------------------------------------
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] mem_addr_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic        cp0_en_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        kill_mem_o
);

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // CP0 bypass: an mtc0 in MEM this cycle has not reached CP0 yet, so
    // its data takes precedence over the register values.
    // ------------------------------------------------------------------
    logic [31:0] eff_status;
    logic [1:0]  eff_cause_sw;
    logic [31:0] eff_epc;
    logic [7:0]  eff_ip;
    logic        int_pending;

    assign eff_status   = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
    assign eff_cause_sw = (cp0_we_i && cp0_waddr_i == CP0_CAUSE)  ? cp0_wdata_i[9:8]
                                                                  : cp0_cause_i[9:8];
    assign eff_epc      = (cp0_we_i && cp0_waddr_i == CP0_EPC)    ? cp0_wdata_i : cp0_epc_i;

    // Only the software interrupt bits [9:8] are writable by mtc0; the
    // hardware lines [15:10] always come from the register.
    assign eff_ip      = {cp0_cause_i[15:10], eff_cause_sw};
    assign int_pending = ((eff_ip & eff_status[15:8]) != 8'd0)
                         && eff_status[0] && !eff_status[1];

    // ------------------------------------------------------------------
    // Priority encoder
    // ------------------------------------------------------------------
    logic        exc_any;
    logic [31:0] exc_code;
    logic        exc_bad_we;
    logic [31:0] exc_bad_addr;
    logic        exc_is_eret;
    logic        detect;

    // NOTE: every signal gets a default before the if-chain, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        exc_any      = 1'b1;
        exc_code     = 32'h0;
        exc_bad_we   = 1'b0;
        exc_bad_addr = 32'h0;
        exc_is_eret  = 1'b0;
        if (int_pending) begin
            exc_code = 32'h1;
        end else if (exc_flags_i[0]) begin
            exc_code     = 32'h4;
            exc_bad_we   = 1'b1;
            exc_bad_addr = pc_i;
        end else if (exc_flags_i[1]) begin
            exc_code = 32'ha;
        end else if (exc_flags_i[2]) begin
            exc_code = 32'h8;
        end else if (exc_flags_i[3]) begin
            exc_code = 32'h9;
        end else if (exc_flags_i[4]) begin
            exc_code = 32'hc;
        end else if (exc_flags_i[5]) begin
            exc_code = 32'hd;
        end else if (exc_flags_i[6]) begin
            exc_code     = 32'h4;
            exc_bad_we   = 1'b1;
            exc_bad_addr = mem_addr_i;
        end else if (exc_flags_i[7]) begin
            exc_code     = 32'h5;
            exc_bad_we   = 1'b1;
            exc_bad_addr = mem_addr_i;
        end else if (exc_flags_i[8]) begin
            exc_code    = 32'he;
            exc_is_eret = 1'b1;
        end else begin
            exc_any = 1'b0;
        end
    end

    // Bubbles carry no PC to restart from, so even interrupts wait for a
    // valid instruction; a stalled instruction is re-evaluated next cycle.
    assign detect = (state == IDLE) && valid_i && !stall_i && exc_any;

    // ------------------------------------------------------------------
    // Sequencer and registered commit outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            cp0_en_o            <= 1'b0;
            excepttype_o        <= 32'h0;
            current_inst_addr_o <= 32'h0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= 32'h0;
            flush_o             <= 1'b0;
            new_pc_o            <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (detect) begin
                        state               <= FLUSH;
                        cp0_en_o            <= 1'b1;
                        flush_o             <= 1'b1;
                        excepttype_o        <= exc_code;
                        current_inst_addr_o <= pc_i;
                        is_in_delayslot_o   <= is_in_delayslot_i;
                        new_pc_o            <= exc_is_eret ? eff_epc : EXC_VECTOR;
                        if (exc_bad_we) begin
                            bad_addr_o <= exc_bad_addr;
                        end
                    end else begin
                        cp0_en_o     <= 1'b0;
                        flush_o      <= 1'b0;
                        excepttype_o <= 32'h0;
                    end
                end
                FLUSH: begin
                    // The commit was held for exactly this cycle; the
                    // instruction now in MEM is killed and never evaluated.
                    state        <= IDLE;
                    cp0_en_o     <= 1'b0;
                    flush_o      <= 1'b0;
                    excepttype_o <= 32'h0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign kill_mem_o = (state == FLUSH);

endmodule

// File: tb/tb_exception_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exception_ctrl
//
// Directed bench for exception_ctrl. Inputs change 1 ns after a rising edge,
// and outputs are compared at that same point, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] mem_addr_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        cp0_en_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        kill_mem_o;

    int n_checks = 0;
    int n_fail   = 0;

    exception_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_i             (valid_i),
        .stall_i             (stall_i),
        .pc_i                (pc_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .exc_flags_i         (exc_flags_i),
        .mem_addr_i          (mem_addr_i),
        .cp0_we_i            (cp0_we_i),
        .cp0_waddr_i         (cp0_waddr_i),
        .cp0_wdata_i         (cp0_wdata_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .cp0_en_o            (cp0_en_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .kill_mem_o          (kill_mem_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Common checks for the cycle in which a commit is visible.
    task automatic check_commit(input string tag, input logic [31:0] code,
                                input logic [31:0] pc, input logic [31:0] npc);
        check({tag, "_en"},    cp0_en_o, 32'd1);
        check({tag, "_flush"}, flush_o, 32'd1);
        check({tag, "_kill"},  kill_mem_o, 32'd1);
        check({tag, "_code"},  excepttype_o, code);
        check({tag, "_pc"},    current_inst_addr_o, pc);
        check({tag, "_npc"},   new_pc_o, npc);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},    cp0_en_o, 32'd0);
        check({tag, "_flush"}, flush_o, 32'd0);
        check({tag, "_kill"},  kill_mem_o, 32'd0);
        check({tag, "_code"},  excepttype_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        stall_i = 1'b0;
        pc_i = 32'h0;
        is_in_delayslot_i = 1'b0;
        exc_flags_i = 9'h0;
        mem_addr_i = 32'h0;
        cp0_we_i = 1'b0;
        cp0_waddr_i = 5'd0;
        cp0_wdata_i = 32'h0;
        cp0_status_i = 32'h0;
        cp0_cause_i = 32'h0;
        cp0_epc_i = 32'h0;
        tick();
        tick();

        // Reset state
        check_quiet("reset");
        check("reset_pc",  current_inst_addr_o, 32'h0);
        check("reset_bad", bad_addr_o, 32'h0);
        check("reset_npc", new_pc_o, 32'h0);
        check("reset_ds",  is_in_delayslot_o, 32'd0);
        rst = 1'b0;
        tick();
        check_quiet("idle");

        // Syscall, not in delay slot
        valid_i = 1'b1;
        pc_i = 32'hBFC0_0100;
        exc_flags_i = 9'h004;
        tick();
        check_commit("sys", 32'h8, 32'hBFC0_0100, 32'hBFC0_0380);
        check("sys_ds", is_in_delayslot_o, 32'd0);
        exc_flags_i = 9'h0;
        pc_i = 32'hBFC0_0104;
        tick();
        check_quiet("sys_after");
        check("sys_hold_pc",  current_inst_addr_o, 32'hBFC0_0100);
        check("sys_hold_npc", new_pc_o, 32'hBFC0_0380);

        // Store misaligned loads a known BadVAddr
        pc_i = 32'h8000_0200;
        mem_addr_i = 32'h8000_0011;
        exc_flags_i = 9'h080;
        tick();
        check_commit("st", 32'h5, 32'h8000_0200, 32'hBFC0_0380);
        check("st_bad", bad_addr_o, 32'h8000_0011);
        exc_flags_i = 9'h0;
        tick();

        // Overflow beats load misaligned; BadVAddr must not change
        pc_i = 32'h8000_1000;
        mem_addr_i = 32'h8000_0003;
        is_in_delayslot_i = 1'b1;
        exc_flags_i = 9'h050;
        tick();
        check_commit("ov", 32'hc, 32'h8000_1000, 32'hBFC0_0380);
        check("ov_ds",  is_in_delayslot_o, 32'd1);
        check("ov_bad", bad_addr_o, 32'h8000_0011);
        exc_flags_i = 9'h0;
        is_in_delayslot_i = 1'b0;
        tick();

        // Fetch misaligned: BadVAddr comes from the PC
        pc_i = 32'h8000_0102;
        exc_flags_i = 9'h001;
        tick();
        check_commit("fetch", 32'h4, 32'h8000_0102, 32'hBFC0_0380);
        check("fetch_bad", bad_addr_o, 32'h8000_0102);
        exc_flags_i = 9'h0;
        tick();

        // Interrupt through a same-cycle mtc0 Status
        pc_i = 32'h8000_0300;
        cp0_cause_i = 32'h0000_0400;
        cp0_we_i = 1'b1;
        cp0_waddr_i = 5'd12;
        cp0_wdata_i = 32'h0000_0401;
        tick();
        check_commit("int", 32'h1, 32'h8000_0300, 32'hBFC0_0380);
        cp0_we_i = 1'b0;
        tick();

        // Same but a bubble: nothing commits
        valid_i = 1'b0;
        cp0_we_i = 1'b1;
        tick();
        check_quiet("int_bubble");

        // Same with EXL set: masked
        valid_i = 1'b1;
        cp0_wdata_i = 32'h0000_0403;
        tick();
        check_quiet("int_exl");

        // Software interrupt via same-cycle mtc0 Cause[8]
        cp0_cause_i = 32'h0;
        cp0_status_i = 32'h0000_0101;
        cp0_waddr_i = 5'd13;
        cp0_wdata_i = 32'h0000_0100;
        pc_i = 32'h8000_0400;
        tick();
        check_commit("swint", 32'h1, 32'h8000_0400, 32'hBFC0_0380);
        cp0_we_i = 1'b0;
        cp0_status_i = 32'h0;
        tick();

        // Eret with same-cycle mtc0 EPC
        pc_i = 32'h8000_0500;
        cp0_epc_i = 32'h0000_1000;
        cp0_we_i = 1'b1;
        cp0_waddr_i = 5'd14;
        cp0_wdata_i = 32'h0000_2000;
        exc_flags_i = 9'h100;
        tick();
        check_commit("eret", 32'he, 32'h8000_0500, 32'h0000_2000);
        cp0_we_i = 1'b0;
        exc_flags_i = 9'h0;
        tick();

        // Reserved instruction held under stall for 3 cycles
        pc_i = 32'h8000_0600;
        exc_flags_i = 9'h002;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("stall");
        end
        stall_i = 1'b0;
        tick();
        check_commit("ri", 32'ha, 32'h8000_0600, 32'hBFC0_0380);
        // Back-to-back flagged instruction during FLUSH is ignored
        pc_i = 32'h8000_0604;
        exc_flags_i = 9'h008;
        tick();
        check_quiet("b2b");
        check("b2b_pc", current_inst_addr_o, 32'h8000_0600);
        exc_flags_i = 9'h0;
        tick();

        // Reset arriving in FLUSH
        pc_i = 32'h8000_0700;
        exc_flags_i = 9'h004;
        tick();
        check_commit("pre_rst", 32'h8, 32'h8000_0700, 32'hBFC0_0380);
        rst = 1'b1;
        exc_flags_i = 9'h0;
        tick();
        check_quiet("rst_flush");
        check("rst_flush_pc",  current_inst_addr_o, 32'h0);
        check("rst_flush_npc", new_pc_o, 32'h0);
        rst = 1'b0;
        tick();
        check_quiet("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
